// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - four-core round-robin arbiter onto one synchronous shared RAM port
// Optional feature: define ARB_LOCK_EN to let a core hold the grant across transactions via lock[].
module shared_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [3:0]        we,
    input  logic [3:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [DATA_W-1:0] wdata3,
    output logic [3:0]        gnt,
    output logic [3:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        ptr;
    logic [1:0]        win;
    logic              we_q;
    logic [3:0]        gnt_q;
    logic [3:0]        ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        rr_idx;
    logic              rr_found;
    logic [1:0]        pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Search ptr+1, ptr+2, ptr+3, ptr; the first active requester wins.
    always_comb begin
        logic [1:0] cand;
        rr_found = 1'b0;
        rr_idx   = ptr;
        cand     = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic lock_active;

    // While locked, ptr still names the locked core because ACK sets ptr to the winner.
    assign pick = (lock_active && req[ptr]) ? ptr : rr_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_active <= 1'b0;
        end else if (state == S_ACK) begin
            lock_active <= lock[win];
        end else if (state == S_IDLE && !req[ptr]) begin
            lock_active <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign pick        = rr_idx;
    assign unused_lock = ^lock;
`endif

    always_comb begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
        case (pick)
            2'd0: begin sel_addr = addr0; sel_wdata = wdata0; end
            2'd1: begin sel_addr = addr1; sel_wdata = wdata1; end
            2'd2: begin sel_addr = addr2; sel_wdata = wdata2; end
            default: begin sel_addr = addr3; sel_wdata = wdata3; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|req) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_ACK;
            S_ACK:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= 2'd3;
            win     <= 2'd0;
            we_q    <= 1'b0;
            gnt_q   <= 4'b0;
            ack_q   <= 4'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack_q <= 4'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        win     <= pick;
                        gnt_q   <= onehot(pick);
                        we_q    <= we[pick];
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                S_CAPTURE: begin
                    // The RAM registered its output on the edge that closed ISSUE.
                    if (!we_q) rdata_q <= mem_rdata;
                    ack_q <= gnt_q;
                end
                S_ACK: begin
                    gnt_q <= 4'b0;
                    ptr   <= win;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so they fall as soon as reset asserts.
    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = (state == S_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != S_IDLE);
    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Four-requester round-robin arbiter that serialises read and write accesses from the four rv32e_soc cores onto one single-ported, synchronous shared scratch memory. It replaces the free-running multi-port work array with a single memory port. It grants one core per transaction, drives the memory port, and returns read data with a one-cycle acknowledge. Sits between the cores' work-array I/O ports and the shared RAM in the top-level app.

## Interface
Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock (24 MHz).
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- req  input  4  per-core request; bit i belongs to core i; held high until ack[i].
- we  input  4  per-core write enable; 1 = write, 0 = read; stable while req high.
- lock  input  4  per-core lock request; used only with ARB_LOCK_EN.
- addr0..addr3  input  ADDR_W  per-core address; stable while req high.
- wdata0..wdata3  input  DATA_W  per-core write data; stable while req high.
- gnt  output  4  one-hot registered grant; 0 when idle.
- ack  output  4  one-hot, one-cycle transaction-complete pulse.
- rdata  output  DATA_W  registered read data; valid while ack is high.
- busy  output  1  high in any state other than IDLE.
- mem_en  output  1  memory access strobe, high only in ISSUE.
- mem_we  output  1  memory write strobe, high only in ISSUE for a write.
- mem_addr  output  ADDR_W  address of the granted core.
- mem_wdata  output  DATA_W  write data of the granted core.
- mem_rdata  input  DATA_W  memory read data, registered by the RAM one clock after mem_en.

## Operation
- FSM has four states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE -> ISSUE when any req bit is set.
  - The winner is latched into the winner index and gnt.
  - we, addr and wdata of the winner are latched into the mem_* registers.
- ISSUE -> CAPTURE unconditionally.
  - mem_en = 1.
  - mem_we = latched we.
- CAPTURE -> ACK unconditionally.
  - For a read, rdata <= mem_rdata.
  - For a write, rdata holds its previous value.
- ACK -> IDLE unconditionally.
  - ack[winner] = 1.
  - gnt clears on exit.
  - The round-robin pointer is set to the winner index.
- Round-robin order, searched from pointer: ptr+1, ptr+2, ptr+3, ptr (mod 4). The first requester found wins. The pointer resets to 3, so core 0 has top priority after reset.
- A req bit still high in the IDLE cycle after its ack counts as a new request. Cores update req on the edge that samples ack, so a registered req drops in time.
- req bits that drop before they are granted are ignored. There is no queueing.
- Memory writes are not observable to reads in the same transaction. A read issued after a write's ack sees the written value.

## Timing
- Reset values:
  - gnt = 0, ack = 0, rdata = 0, busy = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - State = IDLE, pointer = 3.
- Latency: req sampled high in IDLE at cycle 0 gives ISSUE at 1, CAPTURE at 2, and ack/rdata at 3.
- Throughput: one transaction per 4 cycles. The fourth core to be served waits at most 12 cycles after its request is sampled.
- Simultaneous requests: exactly one grant per transaction, chosen by round-robin. There is never more than one hot bit in gnt or ack.
- Reset asserted mid-transaction: mem_en and mem_we drop asynchronously, no ack is issued, and the pointer returns to 3. The aborted core must re-request.
- Addresses wrap naturally at 2^ADDR_W. The arbiter performs no address arithmetic.

## Configuration
- ARB_LOCK_EN defined:
  - If lock[winner] is high in ACK, the next IDLE grants the same core, provided its req is high, ignoring round-robin order.
  - The pointer is not advanced past a locked core.
  - If the locked core drops req, the lock ends and normal arbitration resumes that cycle.
  - Purpose: atomic read-modify-write sequences.
- ARB_LOCK_EN undefined:
  - The lock port is present but ignored, so instantiation is identical.
  - Pure round-robin.

## Test plan
- Reset release, no requests -> gnt = 0, busy = 0, mem_en never high for 20 cycles.
- Core 2 reads address 0x45 with RAM[0x45] = 0xA7 -> mem_en high at cycle 1, ack = 4'b0100 and rdata = 0xA7 at cycle 3.
- All four cores request from reset -> grants in order 0,1,2,3, and a second round gives 0,1,2,3 again, with 4 cycles between consecutive acks.
- Core 1 writes 0x3C to 0x10, then core 3 reads 0x10 -> core 3 gets rdata = 0x3C, and mem_we was high exactly one cycle.
- Reset pulled low during CAPTURE of a core-0 read -> no ack; after release, pointer = 3 and core 0 is granted first.
- ARB_LOCK_EN defined, core 1 holds lock and req while cores 0/2/3 request -> core 1 is granted on 3 consecutive transactions; after lock drops, the next grant goes to core 2.
